// File: rtl/clb_config_sequencer.sv
// clb_config_sequencer
//   Configuration controller for one CLB built from a chain of
//   look_up_table_interconnect_config slices. It takes configuration words
//   from an upstream loader over a valid/ready handshake. It shifts them out
//   LSB-first on the shared bit_in line. The slices are loaded one after
//   another, with a one-cycle GAP between consecutive slices.
//
// Ports
//   clk, reset    clock (posedge) and asynchronous active-high reset
//   start         one-cycle request to configure the CLB (honoured in IDLE only)
//   abort         synchronous cancel, honoured in SHIFT/GAP
//   word_in/word_valid/word_ready
//                 configuration word stream; word_in bit 0 is shifted first
//   bit_out       serial configuration bit to every slice's bit_in
//   cfg_en        slices capture bit_out only while this is high
//   prgm_b        active-low global program (low while configuring)
//   clb_prgm_b    CLB program enable to the first slice (high while configuring)
//   lut_sel       index of the slice being loaded
//   lut_done      one-cycle pulse in each GAP cycle
//   busy          state is SHIFT or GAP
//   done          one-cycle completion pulse
//   aborted       one-cycle pulse when an abort is taken
module clb_config_sequencer #(
  parameter int NUM_LUTS     = 3,
  parameter int BITS_PER_LUT = 37,
  parameter int WORD_W       = 8,
  localparam int LSEL_W      = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              bit_out,
  output logic              cfg_en,
  output logic              prgm_b,
  output logic              clb_prgm_b,
  output logic [LSEL_W-1:0] lut_sel,
  output logic              lut_done,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int TOTAL_BITS  = NUM_LUTS * BITS_PER_LUT;
  localparam int TOTAL_WORDS = (TOTAL_BITS + WORD_W - 1) / WORD_W;
  localparam int CNT_W       = (BITS_PER_LUT > 1) ? $clog2(BITS_PER_LUT) : 1;
  localparam int WB_W        = $clog2(WORD_W + 1);
  localparam int WA_W        = $clog2(TOTAL_WORDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   sreg_q, sreg_d;
  logic [WB_W-1:0]     wbits_q, wbits_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WA_W-1:0]     words_acc_q, words_acc_d;
  logic [LSEL_W-1:0]   lut_sel_q, lut_sel_d;
  logic                bit_out_q, bit_out_d;
  logic                aborted_q, aborted_d;

  logic                in_shift;
  logic                shift_en;
  logic                ready;
  logic                load;
  logic                slice_end;
  logic                last_lut;
  logic [WORD_W-1:0]   sreg_shr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sreg_q      <= '0;
      wbits_q     <= '0;
      bit_cnt_q   <= '0;
      words_acc_q <= '0;
      lut_sel_q   <= '0;
      bit_out_q   <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      wbits_q     <= wbits_d;
      bit_cnt_q   <= bit_cnt_d;
      words_acc_q <= words_acc_d;
      lut_sel_q   <= lut_sel_d;
      bit_out_q   <= bit_out_d;
      aborted_q   <= aborted_d;
    end
  end

  always_comb begin
    in_shift  = (state_q == S_SHIFT);
    shift_en  = in_shift && (wbits_q != '0);
    // A new word may land in the same cycle the last buffered bit leaves,
    // which keeps the stream bubble-free when word_valid stays high.
    ready     = in_shift && (words_acc_q < WA_W'(TOTAL_WORDS)) &&
                ((wbits_q == '0) || ((wbits_q == WB_W'(1)) && shift_en));
    load      = ready && word_valid;
    slice_end = shift_en && (bit_cnt_q == CNT_W'(BITS_PER_LUT - 1));
    last_lut  = (lut_sel_q == LSEL_W'(NUM_LUTS - 1));
    sreg_shr  = sreg_q >> 1;

    state_d     = state_q;
    sreg_d      = sreg_q;
    wbits_d     = wbits_q;
    bit_cnt_d   = bit_cnt_q;
    words_acc_d = words_acc_q;
    lut_sel_d   = lut_sel_q;
    bit_out_d   = bit_out_q;
    aborted_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_SHIFT;
          sreg_d      = '0;
          wbits_d     = '0;
          bit_cnt_d   = '0;
          words_acc_d = '0;
          lut_sel_d   = '0;
          bit_out_d   = 1'b0;
        end
      end
      S_SHIFT: begin
        if (shift_en) begin
          sreg_d    = sreg_shr;
          bit_out_d = sreg_shr[0];
          wbits_d   = wbits_q - WB_W'(1);
          if (!slice_end) bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
        // Load wins over the shift of the final buffered bit.
        if (load) begin
          sreg_d      = word_in;
          bit_out_d   = word_in[0];
          wbits_d     = WB_W'(WORD_W);
          words_acc_d = words_acc_q + WA_W'(1);
        end
        if (slice_end) begin
          if (last_lut) begin
            // Leftover bits of the final word are never shifted out.
            state_d   = S_DONE;
            sreg_d    = '0;
            wbits_d   = '0;
            bit_out_d = 1'b0;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        // The word remainder is kept so it carries into the next slice.
        state_d   = S_SHIFT;
        lut_sel_d = lut_sel_q + LSEL_W'(1);
        bit_cnt_d = '0;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides slice end and word load in both busy states.
    if (abort && (state_q == S_SHIFT || state_q == S_GAP)) begin
      state_d   = S_IDLE;
      aborted_d = 1'b1;
      sreg_d    = '0;
      wbits_d   = '0;
      bit_out_d = 1'b0;
    end
  end

  assign busy       = (state_q == S_SHIFT) || (state_q == S_GAP);
  assign prgm_b     = !busy;
  assign clb_prgm_b = busy;
  assign cfg_en     = shift_en;
  assign word_ready = ready;
  assign bit_out    = bit_out_q;
  assign lut_sel    = lut_sel_q;
  assign lut_done   = (state_q == S_GAP);
  assign done       = (state_q == S_DONE);
  assign aborted    = aborted_q;

endmodule

// File: tb/tb_clb_config_sequencer.sv
// Directed bench for clb_config_sequencer: default configuration plus a
// single-slice, one-bit-word instance.
module tb_clb_config_sequencer;

  logic       clk;
  logic       reset;
  logic       start, abort, word_valid;
  logic [7:0] word_in;
  logic       word_ready, bit_out, cfg_en, prgm_b, clb_prgm_b;
  logic [1:0] lut_sel;
  logic       lut_done, busy, done, aborted;

  logic       s_start, s_abort, s_valid;
  logic [0:0] s_word;
  logic       s_ready, s_bit_out, s_cfg_en, s_prgm_b, s_clb_prgm_b;
  logic [0:0] s_lut_sel;
  logic       s_lut_done, s_busy, s_done, s_aborted;

  clb_config_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
    .bit_out(bit_out), .cfg_en(cfg_en), .prgm_b(prgm_b),
    .clb_prgm_b(clb_prgm_b), .lut_sel(lut_sel), .lut_done(lut_done),
    .busy(busy), .done(done), .aborted(aborted)
  );

  clb_config_sequencer #(.NUM_LUTS(1), .BITS_PER_LUT(5), .WORD_W(1)) dut_small (
    .clk(clk), .reset(reset), .start(s_start), .abort(s_abort),
    .word_in(s_word), .word_valid(s_valid), .word_ready(s_ready),
    .bit_out(s_bit_out), .cfg_en(s_cfg_en), .prgm_b(s_prgm_b),
    .clb_prgm_b(s_clb_prgm_b), .lut_sel(s_lut_sel), .lut_done(s_lut_done),
    .busy(s_busy), .done(s_done), .aborted(s_aborted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int passed = 0;
  int total  = 0;

  // Per-run observations.
  int   r_hs, r_cfg, r_ld1, r_ld2, r_ldn, r_done, r_stall, r_viol;
  int   r_sel51, r_abort, r_stream_err;
  logic [2:0]  r_post_abort;
  logic [10:0] r_rst_vec;
  logic        stream [0:127];

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input int k);
    logic [7:0] w;
    w = 8'(k / 8 + 1);
    return w[k % 8];
  endfunction

  function automatic int stream_errors(input int nbits);
    int e;
    e = 0;
    for (int k = 0; k < nbits; k++)
      if (stream[k] !== exp_bit(k)) e++;
    return e;
  endfunction

  // One configuration attempt on the default instance. Cycle 0 carries start.
  task automatic run_seq(input int start2, input int abort_c, input int drop_c,
                         input int reset_c);
    int wi;
    r_hs = 0; r_cfg = 0; r_ld1 = -1; r_ld2 = -1; r_ldn = 0; r_done = -1;
    r_stall = 0; r_viol = 0; r_sel51 = -1; r_abort = -1;
    r_post_abort = 'x; r_rst_vec = 'x;
    wi = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start      = (c == 0) || (c == start2);
      abort      = (c == abort_c);
      word_valid = !(drop_c >= 0 && c >= drop_c && c < drop_c + 3);
      word_in    = 8'(wi + 1);
      #1;
      if (word_valid && word_ready) begin
        wi++;
        r_hs++;
      end
      if (cfg_en) begin
        if (r_cfg < 128) stream[r_cfg] = bit_out;
        r_cfg++;
      end
      if (lut_done) begin
        r_ldn++;
        if (r_ld1 < 0) r_ld1 = c;
        else if (r_ld2 < 0) r_ld2 = c;
      end
      if (busy && !lut_done && !cfg_en) r_stall++;
      if (busy && prgm_b) r_viol++;
      if (c == 51) r_sel51 = int'(lut_sel);
      if (aborted && r_abort < 0) begin
        r_abort = c;
        r_post_abort = {prgm_b, clb_prgm_b, word_ready};
      end
      if (done) begin
        r_done = c;
        break;
      end
      if (c == reset_c) begin
        reset = 1'b1;
        #1;
        r_rst_vec = {word_ready, bit_out, cfg_en, prgm_b, clb_prgm_b,
                     lut_sel, lut_done, busy, done, aborted};
        break;
      end
      if (abort_c >= 0 && c > abort_c + 20) break;
    end
    start = 1'b0;
    abort = 1'b0;
    word_valid = 1'b0;
  endtask

  localparam logic [10:0] RST_VEC = 11'b000_1_0_00_0000;

  initial begin
    logic [4:0] pat;
    int s_wi, s_cnt, s_err, s_done_c, s_ldn;

    reset = 1'b1;
    start = 1'b0; abort = 1'b0; word_valid = 1'b0; word_in = 8'h00;
    s_start = 1'b0; s_abort = 1'b0; s_valid = 1'b0; s_word = 1'b0;
    #1;
    check("reset_outputs",
          {word_ready, bit_out, cfg_en, prgm_b, clb_prgm_b, lut_sel,
           lut_done, busy, done, aborted}, RST_VEC);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Step 1: plain run, word_valid held high.
    run_seq(-1, -1, -1, -1);
    $display("run normal: hs=%0d cfg=%0d lut_done@%0d,%0d done@%0d", r_hs, r_cfg, r_ld1, r_ld2, r_done);
    check("norm_handshakes", r_hs, 14);
    check("norm_cfg_en_cycles", r_cfg, 111);
    check("norm_lut_done1", r_ld1, 39);
    check("norm_lut_done2", r_ld2, 77);
    check("norm_lut_done_cnt", r_ldn, 2);
    check("norm_done_cycle", r_done, 115);
    check("norm_stream_errs", stream_errors(111), 0);
    check("norm_idle_busy_cycles", r_stall, 1);
    check("norm_prgm_b_high_busy", r_viol, 0);

    // Step 2: word_valid low for 3 cycles at the 5th word boundary.
    run_seq(-1, -1, 33, -1);
    $display("run underrun: cfg=%0d stall=%0d done@%0d", r_cfg, r_stall, r_done);
    check("under_cfg_en_cycles", r_cfg, 111);
    check("under_stall_cycles", r_stall, 4);
    check("under_prgm_b_high_busy", r_viol, 0);
    check("under_done_cycle", r_done, 118);
    check("under_stream_errs", stream_errors(111), 0);

    // Step 3: a second start at cycle 50 is ignored.
    run_seq(50, -1, -1, -1);
    $display("run restart: sel51=%0d done@%0d", r_sel51, r_done);
    check("start2_lut_sel_c51", r_sel51, 1);
    check("start2_lut_done2", r_ld2, 77);
    check("start2_done_cycle", r_done, 115);
    check("start2_stream_errs", stream_errors(111), 0);

    // Step 4: abort at cycle 60, then a fresh full run.
    run_seq(-1, 60, -1, -1);
    $display("run abort: aborted@%0d post=%b done@%0d", r_abort, r_post_abort, r_done);
    check("abort_pulse_cycle", r_abort, 61);
    check("abort_prgm_clb_ready", r_post_abort, 3'b100);
    check("abort_no_done", r_done, -1);
    run_seq(-1, -1, -1, -1);
    $display("run after abort: done@%0d", r_done);
    check("post_abort_done_cycle", r_done, 115);
    check("post_abort_stream_errs", stream_errors(111), 0);

    // Step 5: asynchronous reset mid-slice, then a full rerun.
    run_seq(-1, -1, -1, 45);
    $display("run reset: vec=%b", r_rst_vec);
    check("midreset_outputs", r_rst_vec, RST_VEC);
    check("midreset_no_done", r_done, -1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_seq(-1, -1, -1, -1);
    $display("run after reset: done@%0d", r_done);
    check("post_reset_done_cycle", r_done, 115);
    check("post_reset_stream_errs", stream_errors(111), 0);

    // Step 6: single slice, 5 bits, one-bit words.
    pat = 5'b01101;
    s_wi = 0; s_cnt = 0; s_err = 0; s_done_c = -1; s_ldn = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      s_start = (c == 0);
      s_valid = 1'b1;
      s_word  = (s_wi < 5) ? pat[s_wi] : 1'b0;
      #1;
      if (s_valid && s_ready) s_wi++;
      if (s_cfg_en) begin
        if (s_cnt >= 5 || s_bit_out !== pat[s_cnt]) s_err++;
        s_cnt++;
      end
      if (s_lut_done) s_ldn++;
      if (s_done) begin
        s_done_c = c;
        break;
      end
    end
    s_start = 1'b0;
    s_valid = 1'b0;
    $display("run small: words=%0d cfg=%0d done@%0d", s_wi, s_cnt, s_done_c);
    check("small_bit_errs", s_err, 0);
    check("small_cfg_en_cycles", s_cnt, 5);
    check("small_no_lut_done", s_ldn, 0);
    check("small_done_cycle", s_done_c, 7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
